svm_vector_loader: RTL and testbench

- Writer side of the SVM engine's vector memories: accepts a word stream over valid/ready, writes support vectors and then test vectors into the engine's SV/test storage, then issues a one-cycle start pulse to the engine and holds off new input until the engine reports done.
- Replaces file-based preloading; sits between the host/DMA stream and the SVM engine.

---
 rtl/svm_pkg.sv | 35 +++
 rtl/svm_vec_index_ctr.sv | 44 ++++
 rtl/svm_vector_loader.sv | 213 +++++++++++++++++++++
 tb/tb_svm_vector_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared definitions for the SVM vector loader: size defaults, state encoding,
// write-target encoding and index-width helper.
// Optional checksum stage is enabled by defining SVM_LOADER_CKSUM_EN.
package svm_pkg;

  localparam int unsigned DEF_DATA_SIZE = 32;
  localparam int unsigned DEF_NUM_FEAT  = 2;
  localparam int unsigned DEF_NUM_SV    = 3;
  localparam int unsigned DEF_NUM_INST  = 2;

  // Write-target encoding on wr_tgt
  localparam logic TGT_SV = 1'b0;
  localparam logic TGT_TV = 1'b1;

  // Index width for a count of n items, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_VEC_W  =
    idx_w((DEF_NUM_SV > DEF_NUM_INST) ? DEF_NUM_SV : DEF_NUM_INST);
  localparam int unsigned DEF_FEAT_W = idx_w(DEF_NUM_FEAT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_SV   = 3'd1,
    ST_LOAD_TV   = 3'd2,
`ifdef SVM_LOADER_CKSUM_EN
    ST_CHECK     = 3'd5,
`endif
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } loader_state_e;

endpackage

// File: rtl/svm_vec_index_ctr.sv
// Nested feature/vector index counter. Feature is the minor index; the
// vector index wraps to zero after last_vec so the counter never leaves range.
module svm_vec_index_ctr
  import svm_pkg::*;
#(
  parameter int unsigned NUM_FEAT = DEF_NUM_FEAT,
  parameter int unsigned VEC_W    = DEF_VEC_W,
  parameter int unsigned FEAT_W   = DEF_FEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              adv,
  input  logic [VEC_W-1:0]  last_vec,
  output logic [VEC_W-1:0]  vec,
  output logic [FEAT_W-1:0] feat,
  output logic              last_c
);

  logic feat_wrap_c;

  // Block-end decode from the current indices
  assign feat_wrap_c = (feat == FEAT_W'(NUM_FEAT - 1));
  assign last_c      = feat_wrap_c && (vec == last_vec);

  // Index registers: clear has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec  <= '0;
      feat <= '0;
    end else if (clear) begin
      vec  <= '0;
      feat <= '0;
    end else if (adv) begin
      if (feat_wrap_c) begin
        feat <= '0;
        vec  <= last_c ? '0 : vec + VEC_W'(1);
      end else begin
        feat <= feat + FEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/svm_vector_loader.sv
// Stream-to-memory writer for the SVM engine: loads support vectors, then
// test vectors, pulses core_start and waits for core_done.
// Define SVM_LOADER_CKSUM_EN to require a trailing XOR checksum word.
module svm_vector_loader
  import svm_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned NUM_FEAT  = DEF_NUM_FEAT,
  parameter int unsigned NUM_SV    = DEF_NUM_SV,
  parameter int unsigned NUM_INST  = DEF_NUM_INST,
  localparam int unsigned VEC_W    = idx_w((NUM_SV > NUM_INST) ? NUM_SV : NUM_INST),
  localparam int unsigned FEAT_W   = idx_w(NUM_FEAT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_go,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 wr_en,
  output logic                 wr_tgt,
  output logic [VEC_W-1:0]     wr_vec,
  output logic [FEAT_W-1:0]    wr_feat,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 err
);

  loader_state_e state_q;
  loader_state_e state_d;

  logic              hs_c;
  logic              wr_en_d;
  logic              err_d;
  logic              ready_d;
  logic              ctr_clear;
  logic              ctr_adv;
  logic              ctr_last;
  logic [VEC_W-1:0]  ctr_vec;
  logic [FEAT_W-1:0] ctr_feat;
  logic [VEC_W-1:0]  ctr_last_vec;

`ifdef SVM_LOADER_CKSUM_EN
  logic [DATA_SIZE-1:0] xor_q;
`endif

  assign hs_c = in_valid && in_ready;

  // Vector bound for the phase currently being loaded
  assign ctr_last_vec = (state_q == ST_LOAD_TV) ? VEC_W'(NUM_INST - 1)
                                                : VEC_W'(NUM_SV - 1);

  svm_vec_index_ctr #(
    .NUM_FEAT (NUM_FEAT),
    .VEC_W    (VEC_W),
    .FEAT_W   (FEAT_W)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .adv      (ctr_adv),
    .last_vec (ctr_last_vec),
    .vec      (ctr_vec),
    .feat     (ctr_feat),
    .last_c   (ctr_last)
  );

  // Next state, framing checks and counter control
  always_comb begin
    state_d   = state_q;
    err_d     = err;
    wr_en_d   = 1'b0;
    ctr_clear = 1'b0;
    ctr_adv   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_go) begin
          state_d   = ST_LOAD_SV;
          ctr_clear = 1'b1;
          err_d     = 1'b0;
        end
      end

      ST_LOAD_SV: begin
        if (hs_c) begin
          wr_en_d = 1'b1;
          if (in_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else if (ctr_last) begin
            state_d   = ST_LOAD_TV;
            ctr_clear = 1'b1;
          end else begin
            ctr_adv = 1'b1;
          end
        end
      end

      ST_LOAD_TV: begin
        if (hs_c) begin
          wr_en_d = 1'b1;
          if (!ctr_last) begin
            if (in_last) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              ctr_adv = 1'b1;
            end
          end else begin
`ifdef SVM_LOADER_CKSUM_EN
            // Checksum word still to come, so in_last here is early
            if (in_last) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = ST_CHECK;
            end
`else
            if (in_last) begin
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
`endif
          end
        end
      end

`ifdef SVM_LOADER_CKSUM_EN
      ST_CHECK: begin
        // Checksum word is compared, never written
        if (hs_c) begin
          if (in_last && (in_data == xor_q)) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif

      ST_START: begin
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (core_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SVM_LOADER_CKSUM_EN
    ready_d = (state_d == ST_LOAD_SV) || (state_d == ST_LOAD_TV) ||
              (state_d == ST_CHECK);
`else
    ready_d = (state_d == ST_LOAD_SV) || (state_d == ST_LOAD_TV);
`endif
  end

  // State and registered outputs; write fields update only on a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      err        <= 1'b0;
      wr_en      <= 1'b0;
      wr_tgt     <= TGT_SV;
      wr_vec     <= '0;
      wr_feat    <= '0;
      wr_data    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready   <= ready_d;
      busy       <= (state_d != ST_IDLE);
      core_start <= (state_d == ST_START);
      err        <= err_d;
      wr_en      <= wr_en_d;
      if (wr_en_d) begin
        wr_tgt  <= (state_q == ST_LOAD_TV) ? TGT_TV : TGT_SV;
        wr_vec  <= ctr_vec;
        wr_feat <= ctr_feat;
        wr_data <= in_data;
      end
    end
  end

`ifdef SVM_LOADER_CKSUM_EN
  // Running XOR of every written data word in the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if ((state_q == ST_IDLE) && load_go) begin
      xor_q <= '0;
    end else if (wr_en_d) begin
      xor_q <= xor_q ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_svm_vector_loader.sv
// Directed bench for svm_vector_loader with a write scoreboard.
// Builds with or without SVM_LOADER_CKSUM_EN.
module tb_svm_vector_loader;

`ifdef SVM_LOADER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int DATA_WORDS  = 10;
  localparam int FRAME_WORDS = DATA_WORDS + CK;

  typedef struct packed {
    logic        tgt;
    logic [1:0]  vec;
    logic [0:0]  feat;
    logic [31:0] data;
  } wr_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        load_go   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        core_done = 1'b0;
  logic [31:0] in_data   = '0;
  logic        in_ready;
  logic        wr_en;
  logic        wr_tgt;
  logic [1:0]  wr_vec;
  logic [0:0]  wr_feat;
  logic [31:0] wr_data;
  logic        core_start;
  logic        busy;
  logic        err;

  int   total;
  int   passed;
  int   failed;
  int   cyc;
  int   widx;
  int   starts;
  int   start_cyc;
  int   last_acc_cyc;
  logic exp_wr;
  logic accepted;
  logic [31:0] good_ck;
  wr_t  q[$];

  svm_vector_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_go    (load_go),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .wr_en      (wr_en),
    .wr_tgt     (wr_tgt),
    .wr_vec     (wr_vec),
    .wr_feat    (wr_feat),
    .wr_data    (wr_data),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Frame payload: SV words 1..6, then TV words 1..4
  function automatic logic [31:0] word_data(input int i);
    if (i < 6) return 32'(i + 1);
    return 32'(i - 5);
  endfunction

  // Expected memory write for data word i of a frame
  function automatic wr_t exp_word(input int i);
    wr_t w;
    if (i < 6) begin
      w.tgt  = 1'b0;
      w.vec  = 2'(i / 2);
      w.feat = 1'(i % 2);
    end else begin
      w.tgt  = 1'b1;
      w.vec  = 2'((i - 6) / 2);
      w.feat = 1'((i - 6) % 2);
    end
    w.data = word_data(i);
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check writes at negedge, record handshake, return at posedge+1
  task automatic cycle();
    wr_t e;
    @(negedge clk);
    cyc++;
    check("wr_en_latency", 64'(wr_en), 64'(exp_wr));
    if (wr_en) begin
      if (q.size() == 0) begin
        check("wr_unexpected", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check("wr_payload", 64'({wr_tgt, wr_vec, wr_feat, wr_data}), 64'(e));
      end
    end
    if (core_start) begin
      starts++;
      start_cyc = cyc;
    end
    exp_wr   = 1'b0;
    accepted = in_valid && in_ready;
    if (accepted) begin
      if (widx < DATA_WORDS) begin
        q.push_back(exp_word(widx));
        exp_wr = 1'b1;
      end
      last_acc_cyc = cyc;
      widx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    if (!accepted) check("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (gap) cycle();
  endtask

  task automatic send_frame(input int nwords, input int last_at, input int gap,
                            input logic [31:0] ck);
    for (int i = 0; i < nwords; i++) begin
      send_word((i < DATA_WORDS) ? word_data(i) : ck, (i == last_at), gap);
    end
  endtask

  task automatic start_frame();
    widx    = 0;
    starts  = 0;
    load_go = 1'b1;
    cycle();
    load_go = 1'b0;
  endtask

  // Successful frame: one start pulse right after the final accept, then done
  task automatic finish_ok();
    int n;
    n = 0;
    while (starts == 0 && n < 8) begin
      cycle();
      n++;
    end
    check("start_count", 64'(starts), 64'(1));
    check("start_align", 64'(start_cyc), 64'(last_acc_cyc + 1));
    check("err_clear", 64'(err), 64'(0));
    check("q_drained", 64'(q.size()), 64'(0));
    load_go = 1'b1;
    cycle();
    load_go = 1'b0;
    cycle();
    check("start_once", 64'(starts), 64'(1));
    check("busy_wait", 64'(busy), 64'(1));
    check("ready_wait", 64'(in_ready), 64'(0));
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    check("busy_done", 64'(busy), 64'(0));
    cycle();
    check("ready_idle", 64'(in_ready), 64'(0));
  endtask

  // Framing-error frame: back in IDLE with err set and no start
  task automatic finish_err();
    repeat (3) cycle();
    check("err_set", 64'(err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_ready", 64'(in_ready), 64'(0));
    check("err_nostart", 64'(starts), 64'(0));
    check("err_q_drained", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0; failed = 0; cyc = 0; widx = 0;
    starts = 0; start_cyc = 0; last_acc_cyc = 0;
    exp_wr = 1'b0; accepted = 1'b0;
    good_ck = '0;
    for (int i = 0; i < DATA_WORDS; i++) good_ck = good_ck ^ word_data(i);

    // Reset values
    #2;
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_start", 64'(core_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_wr_fields", 64'({wr_tgt, wr_vec, wr_feat, wr_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Nominal back-to-back frame
    start_frame();
    check("busy_load", 64'(busy), 64'(1));
    check("ready_load", 64'(in_ready), 64'(1));
    send_frame(FRAME_WORDS, FRAME_WORDS - 1, 0, good_ck);
    finish_ok();

    // Alternate-cycle gaps; core_done while loading is ignored
    start_frame();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    check("done_ignored", 64'({busy, in_ready}), 64'(2'b11));
    send_frame(FRAME_WORDS, FRAME_WORDS - 1, 1, good_ck);
    finish_ok();

    // Early in_last on word 5
    start_frame();
    send_frame(5, 4, 0, good_ck);
    finish_err();

    // Next load_go clears err; missing in_last on the final word
    start_frame();
    check("err_cleared", 64'(err), 64'(0));
    send_frame(FRAME_WORDS, -1, 0, good_ck);
    finish_err();

    // Reset mid-frame after word 3, then a clean frame
    start_frame();
    send_frame(3, -1, 0, good_ck);
    check("wr_inflight", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          64'({wr_en, in_ready, busy, core_start, err, wr_tgt, wr_vec, wr_feat, wr_data}),
          64'(0));
    q.delete();
    exp_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("postrst_idle", 64'({busy, in_ready}), 64'(0));
    start_frame();
    send_frame(FRAME_WORDS, FRAME_WORDS - 1, 0, good_ck);
    finish_ok();

`ifdef SVM_LOADER_CKSUM_EN
    // Wrong checksum word
    start_frame();
    send_frame(FRAME_WORDS, FRAME_WORDS - 1, 0, 32'h0000_0000);
    finish_err();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
